// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an integrated per-bit baud counter.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   P_DATA       - parallel word to send, captured on accept
//   Data_Valid   - send request, honoured only while Busy=0
//   Par_En       - append parity bit
//   Par_Typ      - 0 = even parity, 1 = odd parity
//   Stop2        - 0 = one stop bit, 1 = two stop bits
//   Prescale     - clocks per bit (0 behaves as 1)
//   TX_OUT       - serial line, idle high (registered)
//   Busy         - frame in progress (registered)
//   Frame_Done   - one-clock pulse in the last clock of the frame (registered)
module uart_tx_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    input  logic                  Stop2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Frame_Done
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned CNT_W = PRESCALE_W + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [BIT_W-1:0]        bit_cnt;
    logic [PRESCALE_W-1:0]   baud_cnt;
    logic [PRESCALE_W-1:0]   p_last;     // captured clocks-per-bit minus one
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_r;
    logic                    par_bit_r;
    logic                    stop2_r;
    logic                    stop_cnt;   // set while in the second of two stop bits

    logic bit_end_c;
    logic last_stop_bit_c;
    logic enter_final_stop_c;
    logic pre_last_clk_c;
    logic done_next_c;

    // Look one clock ahead so Frame_Done can be a flop yet line up with the final Busy clock.
    always_comb begin
        bit_end_c          = (baud_cnt == p_last);
        last_stop_bit_c    = !stop2_r || stop_cnt;
        enter_final_stop_c = 1'b0;
        if (bit_end_c) begin
            if (!stop2_r && ((state == DATA && bit_cnt == LAST_BIT && !par_en_r) ||
                             state == PARITY))
                enter_final_stop_c = 1'b1;
            if (state == STOP && stop2_r && !stop_cnt)
                enter_final_stop_c = 1'b1;
        end
        pre_last_clk_c = (state == STOP) && last_stop_bit_c &&
                         ((CNT_W'(baud_cnt) + CNT_W'(1)) == CNT_W'(p_last));
        done_next_c    = (enter_final_stop_c && (p_last == '0)) || pre_last_clk_c;
    end

    // Frame sequencer, baud counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            p_last     <= '0;
            shreg      <= '0;
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            stop2_r    <= 1'b0;
            stop_cnt   <= 1'b0;
            TX_OUT     <= 1'b1;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= done_next_c;
            if (state != IDLE)
                baud_cnt <= bit_end_c ? '0 : baud_cnt + PRESCALE_W'(1);

            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        shreg     <= P_DATA;
                        par_en_r  <= Par_En;
                        par_bit_r <= (^P_DATA) ^ Par_Typ;
                        stop2_r   <= Stop2;
                        p_last    <= (Prescale == '0) ? '0 : Prescale - PRESCALE_W'(1);
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        state  <= DATA;
                        TX_OUT <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_en_r) begin
                                state  <= PARITY;
                                TX_OUT <= par_bit_r;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            TX_OUT  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end_c) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        if (last_stop_bit_c) begin
                            state    <= IDLE;
                            Busy     <= 1'b0;
                            stop_cnt <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: an 8-bit and a 5-bit instance share inputs.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] p_data = '0;
    logic       dv8 = 1'b0;
    logic       dv5 = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop2 = 1'b0;
    logic [7:0] prescale = '0;
    logic       tx8, busy8, done8;
    logic       tx5, busy5, done5;
    logic       sel5 = 1'b0;
    logic       tx_m, busy_m, done_m;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .P_DATA(p_data), .Data_Valid(dv8),
        .Par_En(par_en), .Par_Typ(par_typ), .Stop2(stop2), .Prescale(prescale),
        .TX_OUT(tx8), .Busy(busy8), .Frame_Done(done8)
    );

    uart_tx_param #(.DATA_WIDTH(5), .PRESCALE_W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .P_DATA(p_data[4:0]), .Data_Valid(dv5),
        .Par_En(par_en), .Par_Typ(par_typ), .Stop2(stop2), .Prescale(prescale),
        .TX_OUT(tx5), .Busy(busy5), .Frame_Done(done5)
    );

    assign tx_m   = sel5 ? tx5   : tx8;
    assign busy_m = sel5 ? busy5 : busy8;
    assign done_m = sel5 ? done5 : done8;

    typedef struct {
        logic        use5;
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        logic        st2;
        logic [7:0]  psc;
        int          peff;
        int          nbits;
        logic [15:0] bits;      // expected line level per bit period, bit 0 = start
        int          busy_len;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request; returns at the falling edge of the first frame clock.
    task automatic send(input logic use5, input logic [7:0] data, input logic pen,
                        input logic ptyp, input logic st2, input logic [7:0] psc);
        @(negedge clk);
        sel5     = use5;
        p_data   = data;
        par_en   = pen;
        par_typ  = ptyp;
        stop2    = st2;
        prescale = psc;
        dv8      = !use5;
        dv5      = use5;
        @(negedge clk);
        dv8 = 1'b0;
        dv5 = 1'b0;
    endtask

    // Sample a frame from the current falling edge until Busy drops (bounded).
    task automatic observe(input string name, input int peff, input int nbits,
                           input logic [15:0] exp_bits, input int exp_len,
                           input int change_at, input logic [7:0] new_data);
        logic [15:0] obs;
        int len, unstable, done_pos, done_cnt, idx;
        obs = '0; len = 0; unstable = 0; done_pos = 0; done_cnt = 0;
        for (int k = 0; k < 5000; k++) begin
            if (k == change_at) p_data = new_data;
            if (!busy_m) break;
            len++;
            idx = k / peff;
            if (idx < 16) begin
                if (k % peff == 0) obs[idx] = tx_m;
                else if (tx_m !== obs[idx]) unstable++;
            end
            if (done_m) begin
                done_cnt++;
                done_pos = k + 1;
            end
            @(negedge clk);
        end
        check({name, " bits"}, 32'(obs), 32'(exp_bits));
        check({name, " busy_len"}, 32'(len), 32'(exp_len));
        check({name, " done_pos"}, 32'(done_pos), 32'(exp_len));
        check({name, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({name, " unstable"}, 32'(unstable), 32'd0);
        check({name, " idle_tx"}, 32'(tx_m), 32'd1);
        if (nbits < 1) check({name, " nbits"}, 32'(nbits), 32'd1);
    endtask

    initial begin
        //          use5  data  pen   ptyp  st2   psc  peff nbits bits     busy
        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'd4,   4, 11, 16'h054A,   44};
        vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'd4,   4, 12, 16'h0F4A,   48};
        vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'd0,   1, 10, 16'h0278,   10};
        vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'd1,   1, 10, 16'h0278,   10};
        vecs[4] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'd3,   3, 12, 16'h0FFE,   36};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2,   2, 11, 16'h0400,   22};
        vecs[6] = '{1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 8'd5,   5, 12, 16'h0F00,   60};
        vecs[7] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 8'd255, 255, 10, 16'h0202, 2550};
        vecs[8] = '{1'b1, 8'h16, 1'b1, 1'b0, 1'b0, 8'd2,   2,  8, 16'h00EC,   16};

        // Reset state
        #12;
        check("rst tx8", 32'(tx8), 32'd1);
        check("rst busy8", 32'(busy8), 32'd0);
        check("rst done8", 32'(done8), 32'd0);
        check("rst tx5", 32'(tx5), 32'd1);
        check("rst busy5", 32'(busy5), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].use5, vecs[i].data, vecs[i].pen, vecs[i].ptyp,
                 vecs[i].st2, vecs[i].psc);
            observe($sformatf("vec%0d", i), vecs[i].peff, vecs[i].nbits,
                    vecs[i].bits, vecs[i].busy_len, -1, 8'h00);
        end

        // Data_Valid held high: request ignored while busy, then exactly one idle clock
        @(negedge clk);
        sel5 = 1'b0; p_data = 8'h11; par_en = 1'b0; par_typ = 1'b0;
        stop2 = 1'b0; prescale = 8'd2; dv8 = 1'b1;
        @(negedge clk);
        observe("b2b_first", 2, 10, 16'h0222, 20, 5, 8'h22);
        @(negedge clk);
        check("b2b restart busy", 32'(busy8), 32'd1);
        check("b2b restart tx", 32'(tx8), 32'd0);
        dv8 = 1'b0;
        p_data = 8'h5A;
        observe("b2b_second", 2, 10, 16'h0244, 20, -1, 8'h00);

        // Asynchronous reset during data bit 3, then a clean frame
        send(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'd4);
        repeat (17) @(negedge clk);
        check("pre_rst tx", 32'(tx8), 32'd0);
        check("pre_rst busy", 32'(busy8), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst tx", 32'(tx8), 32'd1);
        check("mid_rst busy", 32'(busy8), 32'd0);
        check("mid_rst done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst idle tx", 32'(tx8), 32'd1);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'd1);
        observe("post_rst", 1, 10, 16'h0278, 10, -1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
